// File: rtl/qspi2sdram_top.sv
// qspi2sdram_top: QSPI fast-read slave that streams 16-bit SDRAM words out MSB first.
// Latency: dout updates 3 sdram_clk cycles after a qspi_clk fall (2-flop sync + registered output).
// Backpressure: at most one SDRAM request in flight; a word not back in time goes out as 16'hFFFF.
// Ports: sdram_clk/rst_n system clock and async active-low reset; qspi_clk/csn/di/holdn/wpn serial
//   slave inputs (wpn unused); dout serial data out (`do` is a reserved word, hence the name);
//   rd_addr/rd_avalid/rd_aready address request; rd_data/rd_valid/rd_ready read-data beat.
module qspi2sdram_top #(
  parameter int          ADDR_W     = 22,
  parameter logic [7:0]  CMD_READ   = 8'h0B,
  parameter int          DUMMY_CLKS = 8
) (
  input  logic              sdram_clk,
  input  logic              rst_n,
  input  logic              qspi_clk,
  input  logic              csn,
  input  logic              di,
  output logic              dout,
  input  logic              wpn,
  input  logic              holdn,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_avalid,
  input  logic              rd_aready,
  input  logic [15:0]       rd_data,
  input  logic              rd_valid,
  output logic              rd_ready
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  localparam logic [7:0] DCNT = 8'(DUMMY_CLKS);

  // [1] is the synchronized value, [2] its previous sample for edge detection
  logic [2:0] qclk_q;
  logic [2:0] csn_q;
  logic [1:0] di_q;
  logic [1:0] hold_q;

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      qclk_q <= '0;
      csn_q  <= '0;
      di_q   <= '0;
      hold_q <= '0;
    end else begin
      qclk_q <= {qclk_q[1:0], qspi_clk};
      csn_q  <= {csn_q[1:0], csn};
      di_q   <= {di_q[0], di};
      hold_q <= {hold_q[0], holdn};
    end
  end

  logic en, q_rise, q_fall, cs_rise, cs_fall;
  assign en      = ~csn_q[1] & hold_q[1];
  assign q_rise  = en & qclk_q[1] & ~qclk_q[2];
  assign q_fall  = en & ~qclk_q[1] & qclk_q[2];
  // Synced csn resets low, so a csn held low through reset yields no falling edge
  // until it has been seen high once.
  assign cs_rise = csn_q[1] & ~csn_q[2];
  assign cs_fall = ~csn_q[1] & csn_q[2];

  state_t             state;
  logic [7:0]         cnt;
  logic [6:0]         cmd_sh;
  logic [22:0]        addr_sh;
  logic [ADDR_W-1:0]  word_addr;
  logic [15:0]        sreg;
  logic [15:0]        buf_dat;
  logic               buf_full;
  logic               req_pend;
  logic               discard;

  logic [7:0]  cmd_full;
  logic [23:0] addr_full;
  logic [15:0] load_word;
  assign cmd_full  = {cmd_sh, di_q[1]};
  assign addr_full = {addr_sh, di_q[1]};
  assign load_word = buf_full ? buf_dat : 16'hFFFF;

  logic unused_ok;
  assign unused_ok = wpn ^ addr_full[23];

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sh    <= '0;
      addr_sh   <= '0;
      word_addr <= '0;
      sreg      <= '0;
      buf_dat   <= '0;
      buf_full  <= 1'b0;
      req_pend  <= 1'b0;
      discard   <= 1'b0;
      dout      <= 1'b0;
      rd_addr   <= '0;
      rd_avalid <= 1'b0;
      rd_ready  <= 1'b0;
    end else begin
      // Request side: launch only when nothing (including a discarded beat) is in flight.
      if (rd_avalid && rd_aready) begin
        rd_avalid <= 1'b0;
        rd_ready  <= 1'b1;
      end else if (req_pend && !rd_avalid && !rd_ready && !cs_rise) begin
        rd_avalid <= 1'b1;
        rd_addr   <= word_addr;
        req_pend  <= 1'b0;
      end
      if (rd_ready && rd_valid) begin
        rd_ready <= 1'b0;
        if (discard) begin
          discard <= 1'b0;
        end else begin
          buf_dat  <= rd_data;
          buf_full <= 1'b1;
        end
      end

      if (cs_rise) begin
        state    <= IDLE;
        dout     <= 1'b0;
        buf_full <= 1'b0;
        req_pend <= 1'b0;
        // Anything still outstanding after this cycle belongs to the aborted frame.
        if (rd_avalid || (rd_ready && !rd_valid)) discard <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (cs_fall) state <= CMD;
          end
          CMD: if (q_rise) begin
            cmd_sh <= cmd_full[6:0];
            if (cnt == 8'd7) begin
              cnt   <= '0;
              state <= (cmd_full == CMD_READ) ? ADDR : IGNORE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ADDR: if (q_rise) begin
            addr_sh <= addr_full[22:0];
            if (cnt == 8'd23) begin
              word_addr <= addr_full[ADDR_W-1:0];
              req_pend  <= 1'b1;
              cnt       <= '0;
              state     <= DUMMY;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          DUMMY: begin
            if (q_rise && cnt != DCNT) begin
              cnt <= cnt + 8'd1;
            end else if (q_fall && cnt == DCNT) begin
              dout  <= load_word[15];
              sreg  <= {load_word[14:0], 1'b0};
              cnt   <= 8'd15;
              state <= DATA;
              if (buf_full) begin
                buf_full  <= 1'b0;
                word_addr <= word_addr + ADDR_W'(1);
                req_pend  <= 1'b1;
              end
            end
          end
          DATA: if (q_fall) begin
            if (cnt == 8'd0) begin
              // Word boundary: consume the prefetch buffer and fetch the next word.
              // On underrun the in-flight request is left to fill the following slot.
              dout <= load_word[15];
              sreg <= {load_word[14:0], 1'b0};
              cnt  <= 8'd15;
              if (buf_full) begin
                buf_full  <= 1'b0;
                word_addr <= word_addr + ADDR_W'(1);
                req_pend  <= 1'b1;
              end
            end else begin
              dout <= sreg[15];
              sreg <= {sreg[14:0], 1'b0};
              cnt  <= cnt - 8'd1;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi2sdram_top.sv
// tb_qspi2sdram_top: directed QSPI master plus SDRAM responder around qspi2sdram_top.
// Latency: one qspi_clk period is 10 sdram_clk periods; dout is sampled just before each rise.
// Backpressure: rd_aready / rd_valid are held low in dedicated steps to stall the DUT.
module tb_qspi2sdram_top;

  localparam time QH = 50ns;

  logic        sdram_clk = 1'b0;
  logic        rst_n;
  logic        qspi_clk;
  logic        csn;
  logic        di;
  logic        dout;
  logic        wpn;
  logic        holdn;
  logic [21:0] rd_addr;
  logic        rd_avalid;
  logic        rd_aready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  int tests = 0;
  int fails = 0;
  int beat;
  int avalid_cyc;

  logic [21:0] got_addr[$];
  logic [21:0] exp_addr[$];
  logic [15:0] got_word[$];
  logic [15:0] exp_word[$];

  qspi2sdram_top dut (
    .sdram_clk (sdram_clk),
    .rst_n     (rst_n),
    .qspi_clk  (qspi_clk),
    .csn       (csn),
    .di        (di),
    .dout      (dout),
    .wpn       (wpn),
    .holdn     (holdn),
    .rd_addr   (rd_addr),
    .rd_avalid (rd_avalid),
    .rd_aready (rd_aready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready)
  );

  always #5ns sdram_clk = ~sdram_clk;

  // SDRAM responder: records accepted addresses, returns A000 + beat index as data.
  initial begin
    logic hs_a, hs_d;
    rd_data    = 16'hA000;
    beat       = 0;
    avalid_cyc = 0;
    forever begin
      @(posedge sdram_clk);
      hs_a = rd_avalid && rd_aready;
      hs_d = rd_ready && rd_valid;
      if (rd_avalid) avalid_cyc++;
      if (hs_a) got_addr.push_back(rd_addr);
      #1ns;
      if (hs_d) begin
        beat++;
        rd_data = 16'hA000 + 16'(beat);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic qbit(input logic b, output logic r);
    di = b;
    #(QH);
    r = dout;
    qspi_clk = 1'b1;
    #(QH);
    qspi_clk = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic unused_b;
    for (int i = n - 1; i >= 0; i--) qbit(v[i], unused_b);
  endtask

  task automatic recv(input int n, output logic [31:0] rx);
    logic r;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      qbit(1'b0, r);
      rx = {rx[30:0], r};
    end
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_nreq"}, got_addr.size(), exp_addr.size());
    while (got_addr.size() > 0 && exp_addr.size() > 0)
      chk({tag, "_addr"}, got_addr.pop_front(), exp_addr.pop_front());
    chk({tag, "_nword"}, got_word.size(), exp_word.size());
    while (got_word.size() > 0 && exp_word.size() > 0)
      chk({tag, "_word"}, got_word.pop_front(), exp_word.pop_front());
    got_addr.delete();
    exp_addr.delete();
    got_word.delete();
    exp_word.delete();
  endtask

  // mode 0: plain 2-word read, 1: hold mid-word, 2: rd_aready stall, 3: rd_valid underrun
  task automatic run_read(input string tag, input logic [23:0] a, input int mode);
    logic [31:0] r1, r2, unused_rx;
    logic [15:0] base;
    logic [21:0] wa;
    int k;
    base = 16'hA000 + 16'(beat);
    for (int i = 0; i < 4; i++) begin
      wa = a[21:0] + 22'(i);
      exp_addr.push_back(wa);
    end
    exp_word.push_back(base);
    if (mode == 3) exp_word.push_back(16'hFFFF);
    exp_word.push_back(base + 16'd1);
    rd_aready = (mode != 2);
    csn = 1'b0;
    #(QH);
    send(32'h0B, 8);
    send({8'h00, a}, 24);
    if (mode == 2) begin
      k = 0;
      while (!rd_avalid && k < 20) begin
        @(negedge sdram_clk);
        k++;
      end
      chk({tag, "_avalid_up"}, rd_avalid, 1);
      repeat (10) begin
        @(negedge sdram_clk);
        chk({tag, "_avalid_hold"}, rd_avalid, 1);
        chk({tag, "_addr_hold"}, rd_addr, a[21:0]);
      end
      rd_aready = 1'b1;
    end
    if (mode == 3) begin
      send(32'h0, 1);
      rd_valid = 1'b0;
      send(32'h0, 7);
    end else begin
      send(32'h0, 8);
    end
    case (mode)
      1: begin
        recv(8, r1);
        #(QH);
        holdn = 1'b0;
        recv(4, unused_rx);
        #(QH);
        holdn = 1'b1;
        recv(24, r2);
        got_word.push_back({r1[7:0], r2[23:16]});
        got_word.push_back(r2[15:0]);
      end
      3: begin
        recv(20, r1);
        rd_valid = 1'b1;
        recv(28, r2);
        got_word.push_back(r1[19:4]);
        got_word.push_back({r1[3:0], r2[27:16]});
        got_word.push_back(r2[15:0]);
      end
      default: begin
        recv(32, r1);
        got_word.push_back(r1[31:16]);
        got_word.push_back(r1[15:0]);
      end
    endcase
    #(QH);
    csn = 1'b1;
    #(4 * QH);
    chk({tag, "_dout_idle"}, dout, 0);
    check_sb(tag);
  endtask

  initial begin
    logic [31:0] rx;
    int snap;
    rst_n = 1'b1;
    qspi_clk = 1'b0;
    csn = 1'b0;
    di = 1'b0;
    wpn = 1'b1;
    holdn = 1'b1;
    rd_aready = 1'b1;
    rd_valid = 1'b1;
    #2ns;
    rst_n = 1'b0;
    #100ns;
    @(negedge sdram_clk);
    chk("rst_avalid", rd_avalid, 0);
    chk("rst_ready", rd_ready, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sdram_clk);

    // csn already low at reset release: a whole read command must be ignored
    send(32'h0B00_0010, 32);
    send(32'h0, 8);
    recv(8, rx);
    chk("stale_csn_dout", rx, 0);
    chk("stale_csn_avalid", avalid_cyc, 0);
    csn = 1'b1;
    #(4 * QH);
    check_sb("stale_csn");

    run_read("read", 24'h000010, 0);

    // unsupported opcode
    snap = avalid_cyc;
    csn = 1'b0;
    #(QH);
    send(32'h03, 8);
    recv(32, rx);
    chk("badop_dout_a", rx, 0);
    recv(24, rx);
    chk("badop_dout_b", rx, 0);
    #(QH);
    csn = 1'b1;
    #(4 * QH);
    chk("badop_avalid", avalid_cyc, snap);
    check_sb("badop");

    // frame aborted after 12 address bits
    snap = avalid_cyc;
    csn = 1'b0;
    #(QH);
    send(32'h0B, 8);
    send(32'hFFF, 12);
    #(QH);
    csn = 1'b1;
    #(4 * QH);
    chk("abort_avalid", avalid_cyc, snap);
    chk("abort_dout", dout, 0);
    check_sb("abort");

    // upper address byte ignored, word address wraps at 2^22
    run_read("wrap", 24'hFFFFFF, 0);
    run_read("hold", 24'h000100, 1);
    run_read("stall", 24'h2AAAAA, 2);
    run_read("underrun", 24'h000200, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qspi2sdram_top.md
QSPI2SDRAM_TOP -- requirements
Module: qspi2sdram_top

Interface
REQ-001 SHALL have parameter ADDR_W, default 22: width of the word address and of rd_addr.
REQ-002 SHALL have parameter CMD_READ, default 8'h0B: the only accepted opcode.
REQ-003 SHALL have parameter DUMMY_CLKS, default 8: number of dummy serial clocks between the address and the data.
REQ-004 SHALL have port sdram_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port qspi_clk, input, 1 bit: serial clock from the master, treated as data and oversampled.
REQ-007 SHALL have port csn, input, 1 bit: chip select, active low.
REQ-008 SHALL have port di, input, 1 bit: serial data in, MSB first.
REQ-009 SHALL have port do, output, 1 bit: serial data out, MSB first.
REQ-010 SHALL have ports wpn and holdn, input, 1 bit each: write-protect (ignored) and hold, active low.
REQ-011 SHALL have port rd_addr, output, ADDR_W bits: SDRAM word read address.
REQ-012 SHALL have port rd_avalid, output, 1 bit: address request valid.
REQ-013 SHALL have port rd_aready, input, 1 bit: address request accepted.
REQ-014 SHALL have port rd_data, input, 16 bits: read data word.
REQ-015 SHALL have ports rd_valid, input, and rd_ready, output, 1 bit each: read-data handshake.

Function
REQ-016 SHALL pass qspi_clk, csn, di and holdn through 2-flop synchronizers, then edge-detect qspi_clk; a rise or fall counts only while synced csn=0 and holdn=1.
REQ-017 SHALL support qspi_clk periods of at least 8 sdram_clk periods (SPI mode 0).
REQ-018 SHALL run an FSM with states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE; a synced csn falling edge moves IDLE->CMD.
REQ-019 CMD SHALL sample 8 bits on qspi rises; if the opcode equals CMD_READ go to ADDR, otherwise go to IGNORE until csn rises.
REQ-020 ADDR SHALL sample 24 bits; the word address is bits [ADDR_W-1:0]. After the 24th bit: load the address, assert rd_avalid, go to DUMMY.
REQ-021 DUMMY SHALL count DUMMY_CLKS rises; at the following fall, go to DATA and drive bit 15 of the first word.
REQ-022 rd_avalid SHALL stay high, with rd_addr stable, until a cycle with rd_aready=1; one outstanding request at most.
REQ-023 After the address is accepted, rd_ready SHALL be 1 until the cycle with rd_valid=1, which writes rd_data into a 1-word prefetch buffer.
REQ-024 In DATA, each qspi fall SHALL shift the next bit of a 16-bit shift register onto do.
REQ-025 After bit 0, the next fall SHALL load the buffer into the shift register, increment rd_addr by 1 (wrapping modulo 2^ADDR_W), and issue the next request.
REQ-026 On underrun (buffer empty at load time), the DUT SHALL shift out 16'hFFFF; the late word fills the following word slot and no extra request is issued.
REQ-027 A synced csn rise in any state SHALL return the FSM to IDLE, clear the buffer and drive do=0.
REQ-028 After a csn rise, a pending rd_avalid SHALL complete its handshake, and the matching data beat SHALL be accepted and discarded.
REQ-029 do SHALL be 0 outside DATA, and do SHALL change within 4 sdram_clk cycles of a qspi_clk fall.

Reset
REQ-030 While rst_n=0 the DUT SHALL be in IDLE with rd_avalid=0, rd_ready=0, rd_addr=0, do=0, buffer empty, and counters and synchronizers cleared.
REQ-031 After reset release, the DUT SHALL ignore a csn already low until csn goes high once.

Verification
REQ-032 Reset: hold rst_n=0 for 100 ns -> rd_avalid=0, rd_ready=0, rd_addr=0, do=0.
REQ-033 Read: rd_aready=1, rd_valid=1, rd_data counting from 16'hA000 on each handshake; opcode 0x0B, address 0x000010, 8 dummy clocks, 32 data clocks -> rd_addr 0x000010 then 0x000011; do carries 16'hA000 then 16'hA001.
REQ-034 Bad opcode 0x03 -> no rd_avalid, do=0 for the whole frame.
REQ-035 csn raised after 12 address bits -> no request; the next full read works normally.
REQ-036 holdn=0 for 4 qspi clocks mid-word -> those clocks are ignored and the output bitstream continues with no bits lost.
REQ-037 rd_aready held 0 for 10 cycles -> rd_avalid and rd_addr stay stable. rd_valid held 0 past a word boundary -> that word is 16'hFFFF and the late data appears in the next word.
